ext_mem_dual_channel_model: RTL and testbench

- Synthesizable off-chip memory responder sitting directly downstream of the HLS top `main` master port (Mout_* / M_Rdata_ram / M_DataRdy).
- Serves two independent byte channels with configurable read and write latency and a base-address window, with per-access byte masking driven by data_ram_size.
- Provides a preload port so an upstream vector loader can initialise contents before start.

---
 rtl/ext_mem_pkg.sv | 26 ++
 rtl/ext_mem_chan_ctrl.sv | 63 ++++++
 rtl/ext_mem_dual_channel_model.sv | 97 +++++++++
 tb/tb_ext_mem_dual_channel_model.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared constants and helpers for the dual-channel external memory responder.
package ext_mem_pkg;

  localparam int unsigned N_CH       = 2;
  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned BYTE_W_DEF = 8;
  // Widest mask a 4-bit size field can describe.
  localparam int unsigned MASK_W     = 16;

  // Low 'size' bits set; size 0 gives an empty mask.
  function automatic logic [MASK_W-1:0] size_to_mask(input logic [3:0] size);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (4'(i) < size);
    end
    return m;
  endfunction

  // True when base <= addr < base + size.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/ext_mem_chan_ctrl.sv
// Per-channel access timing: latency counter, completion pulse and read-data pipeline.
module ext_mem_chan_ctrl
  import ext_mem_pkg::*;
#(
  parameter int unsigned BYTE_W   = BYTE_W_DEF,
  parameter int          RD_DELAY = 2,
  parameter int          WR_DELAY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe,
  input  logic              we,
  input  logic              hit,
  input  logic [BYTE_W-1:0] fetch,
  output logic [BYTE_W-1:0] rdata,
  output logic              rdy
);

  localparam int STAGES = RD_DELAY - 1;

  logic signed [31:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0]  sr_q [STAGES];

  // Next latency count: reads take priority over writes, anything else restarts.
  always_comb begin
    cnt_d = '0;
    if (oe && hit) begin
      cnt_d = (cnt_q < RD_DELAY - 1) ? cnt_q + 1 : '0;
    end else if (we && hit) begin
      cnt_d = (cnt_q < WR_DELAY - 1) ? cnt_q + 1 : '0;
    end
  end

  // Latency counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read pipeline: fetched byte enters the top stage and walks down to stage 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[STAGES-1] <= fetch;
      for (int i = 0; i < STAGES - 1; i++) begin
        sr_q[i] <= sr_q[i+1];
      end
    end
  end

  // Completion pulse and read data output.
  always_comb begin
    rdy   = hit && ((cnt_q == RD_DELAY - 1) || (we && (cnt_q == WR_DELAY - 1)));
    rdata = sr_q[0];
  end

endmodule

// File: rtl/ext_mem_dual_channel_model.sv
// Dual-channel byte memory responder with preload port, masked writes and conflict flag.
module ext_mem_dual_channel_model
  import ext_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned BYTE_W    = BYTE_W_DEF,
  parameter int unsigned MEMSIZE   = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          RD_DELAY  = 2,   // must be >= 2
  parameter int          WR_DELAY  = 1    // must be >= 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_CH-1:0]              Mout_oe_ram,
  input  logic [N_CH-1:0]              Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]       Mout_addr_ram,
  input  logic [N_CH*BYTE_W-1:0]       Mout_Wdata_ram,
  input  logic [7:0]                   Mout_data_ram_size,
  input  logic                         init_we,
  input  logic [$clog2(MEMSIZE)-1:0]   init_addr,
  input  logic [BYTE_W-1:0]            init_data,
  output logic [N_CH*BYTE_W-1:0]       M_Rdata_ram,
  output logic [N_CH-1:0]              M_DataRdy,
  output logic                         err_conflict
);

  localparam int unsigned OFF_W = $clog2(MEMSIZE);

  logic [BYTE_W-1:0] mem [MEMSIZE];

  logic [N_CH-1:0]   hit;
  logic [N_CH-1:0]   wr_en;
  logic [OFF_W-1:0]  off   [N_CH];
  logic [BYTE_W-1:0] fetch [N_CH];
  logic [BYTE_W-1:0] mask  [N_CH];
  logic [BYTE_W-1:0] wdata [N_CH];

  // Per-channel decode: window hit, offset, write qualification, fetch and byte mask.
  always_comb begin
    hit   = '0;
    wr_en = '0;
    off   = '{default: '0};
    fetch = '{default: '0};
    mask  = '{default: '0};
    wdata = '{default: '0};
    for (int c = 0; c < N_CH; c++) begin
      hit[c]   = in_window(32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]), 32'(BASE_ADDR),
                           32'(MEMSIZE));
      off[c]   = OFF_W'(32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]) - 32'(BASE_ADDR));
      // oe together with we is serviced as a read only.
      wr_en[c] = Mout_we_ram[c] && !Mout_oe_ram[c] && hit[c];
      // Fetch before this edge's writes land, so a same-cycle read sees the old byte.
      fetch[c] = (Mout_oe_ram[c] && hit[c]) ? mem[off[c]] : '0;
      mask[c]  = BYTE_W'(size_to_mask(Mout_data_ram_size[c*4 +: 4]));
      wdata[c] = Mout_Wdata_ram[c*BYTE_W +: BYTE_W];
    end
  end

  // Storage writes; later assignments win, so priority is init < ch0 < ch1.
  always_ff @(posedge clock) begin
    if (init_we && (32'(init_addr) < MEMSIZE)) begin
      mem[init_addr] <= init_data;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (wr_en[c]) begin
        mem[off[c]] <= (wdata[c] & mask[c]) | (mem[off[c]] & ~mask[c]);
      end
    end
  end

  // Sticky flag for oe and we raised together on any channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_conflict <= 1'b0;
    end else if (|(Mout_oe_ram & Mout_we_ram)) begin
      err_conflict <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    ext_mem_chan_ctrl #(
      .BYTE_W  (BYTE_W),
      .RD_DELAY(RD_DELAY),
      .WR_DELAY(WR_DELAY)
    ) u_ctrl (
      .clock(clock),
      .reset(reset),
      .oe   (Mout_oe_ram[g]),
      .we   (Mout_we_ram[g]),
      .hit  (hit[g]),
      .fetch(fetch[g]),
      .rdata(M_Rdata_ram[g*BYTE_W +: BYTE_W]),
      .rdy  (M_DataRdy[g])
    );
  end

endmodule

// File: tb/tb_ext_mem_dual_channel_model.sv
// Self-checking bench: behavioural memory model plus directed literal checks and random traffic.
module tb_ext_mem_dual_channel_model;

  localparam int AW = 7;
  localparam int BW = 8;
  localparam int MS = 32;
  localparam int BASE = 0;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    Mout_oe_ram, Mout_we_ram;
  logic [2*AW-1:0] Mout_addr_ram;
  logic [2*BW-1:0] Mout_Wdata_ram;
  logic [7:0]    Mout_data_ram_size;
  logic          init_we;
  logic [4:0]    init_addr;
  logic [BW-1:0] init_data;
  logic [2*BW-1:0] M_Rdata_ram;
  logic [1:0]    M_DataRdy;
  logic          err_conflict;

  ext_mem_dual_channel_model dut (
    .clock             (clock),
    .reset             (reset),
    .Mout_oe_ram       (Mout_oe_ram),
    .Mout_we_ram       (Mout_we_ram),
    .Mout_addr_ram     (Mout_addr_ram),
    .Mout_Wdata_ram    (Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .init_we           (init_we),
    .init_addr         (init_addr),
    .init_data         (init_data),
    .M_Rdata_ram       (M_Rdata_ram),
    .M_DataRdy         (M_DataRdy),
    .err_conflict      (err_conflict)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state.
  int m_mem [MS];
  int m_cnt [2] = '{0, 0};
  int m_rd  [2] = '{0, 0};
  bit m_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ch_addr(input int c);
    return int'(Mout_addr_ram[c*AW +: AW]);
  endfunction

  // Model update at each rising edge, straight from the access rules.
  always @(posedge clock) begin
    int pre [MS];
    pre = m_mem;
    for (int c = 0; c < 2; c++) begin
      int a;
      bit h;
      a = ch_addr(c);
      h = (a >= BASE) && (a < BASE + MS);
      if (reset) begin
        m_cnt[c] = 0;
        m_rd[c]  = 0;
      end else begin
        m_rd[c] = (Mout_oe_ram[c] && h) ? pre[a - BASE] : 0;
        if (Mout_oe_ram[c] && h)      m_cnt[c] = (m_cnt[c] < 1) ? m_cnt[c] + 1 : 0;
        else if (Mout_we_ram[c] && h) m_cnt[c] = 0;
        else                          m_cnt[c] = 0;
      end
    end
    if (reset) m_err = 1'b0;
    else if ((Mout_oe_ram & Mout_we_ram) != 2'b00) m_err = 1'b1;
    if (init_we) m_mem[int'(init_addr)] = int'(init_data);
    for (int c = 0; c < 2; c++) begin
      int a, sz, msk;
      a  = ch_addr(c);
      sz = int'(Mout_data_ram_size[c*4 +: 4]);
      msk = (sz >= 8) ? 255 : ((1 << sz) - 1);
      if (Mout_we_ram[c] && !Mout_oe_ram[c] && a >= BASE && a < BASE + MS) begin
        m_mem[a - BASE] = (int'(Mout_Wdata_ram[c*BW +: BW]) & msk) | (pre[a - BASE] & ~msk & 255);
      end
    end
  end

  // Compare process: every falling edge once the model is in step.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        int a;
        bit h, rdy;
        a = ch_addr(c);
        h = (a >= BASE) && (a < BASE + MS);
        rdy = h && (m_cnt[c] == 1 || (Mout_we_ram[c] && m_cnt[c] == 0));
        check($sformatf("model rdy[%0d]", c), int'(M_DataRdy[c]), int'(rdy));
        check($sformatf("model rdata[%0d]", c), int'(M_Rdata_ram[c*BW +: BW]), m_rd[c]);
      end
      check("model err", int'(err_conflict), int'(m_err));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int c, input bit oe, input bit we, input int addr, input int wd,
                       input int sz);
    Mout_oe_ram[c] = oe;
    Mout_we_ram[c] = we;
    Mout_addr_ram[c*AW +: AW] = AW'(addr);
    Mout_Wdata_ram[c*BW +: BW] = BW'(wd);
    Mout_data_ram_size[c*4 +: 4] = 4'(sz);
  endtask

  task automatic idle();
    drive(0, 0, 0, 127, 0, 8);
    drive(1, 0, 0, 127, 0, 8);
    init_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Mout_oe_ram = '0; Mout_we_ram = '0; Mout_addr_ram = '0; Mout_Wdata_ram = '0;
    Mout_data_ram_size = '0; init_addr = '0; init_data = '0;
    idle();
    step();
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    check("reset rdy", int'(M_DataRdy), 0);
    check("reset rdata", int'(M_Rdata_ram), 0);
    check("reset err", int'(err_conflict), 0);
    step();

    // Preload every byte so the model and DUT agree on all contents.
    for (int i = 0; i < MS; i++) begin
      init_we = 1'b1;
      init_addr = 5'(i);
      init_data = (i == 5) ? 8'hA5 : (i == 3) ? 8'h00 : 8'($urandom);
      step();
    end
    idle();
    step();

    // Held read of offset 5 on ch0; ch1 idle.
    drive(0, 1, 0, 5, 0, 8);
    @(negedge clock);
    check("rd cycle1 rdy0", int'(M_DataRdy[0]), 0);
    step();
    @(negedge clock);
    check("rd cycle2 rdy0", int'(M_DataRdy[0]), 1);
    check("rd cycle2 data0", int'(M_Rdata_ram[7:0]), 'hA5);
    check("rd cycle2 ch1", int'({M_DataRdy[1], M_Rdata_ram[15:8]}), 0);
    idle();
    step();

    // Masked write on ch1: size 4 over 0x00.
    drive(1, 0, 1, 3, 'hFF, 4);
    @(negedge clock);
    check("wr rdy1", int'(M_DataRdy[1]), 1);
    step();
    idle();
    drive(0, 1, 0, 3, 0, 8);
    step();
    @(negedge clock);
    check("masked wr readback", int'(M_Rdata_ram[7:0]), 'h0F);
    idle();
    step();

    // Both channels write offset 7: ch1 wins.
    drive(0, 0, 1, 7, 'h11, 8);
    drive(1, 0, 1, 7, 'h22, 8);
    step();
    idle();
    drive(0, 1, 0, 7, 0, 8);
    step();
    @(negedge clock);
    check("dual wr readback", int'(M_Rdata_ram[7:0]), 'h22);
    idle();
    step();

    // Out-of-window read.
    drive(0, 1, 0, 40, 0, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("miss rdy0", int'(M_DataRdy[0]), 0);
      check("miss data0", int'(M_Rdata_ram[7:0]), 0);
      step();
    end
    idle();
    step();

    // Conflict flag is sticky until reset; memory survives reset.
    drive(0, 1, 1, 9, 'h55, 8);
    @(negedge clock);
    check("err before", int'(err_conflict), 0);
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("err sticky", int'(err_conflict), 1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("err cleared", int'(err_conflict), 0);
    drive(0, 1, 0, 7, 0, 8);
    step();
    @(negedge clock);
    check("mem kept over reset", int'(M_Rdata_ram[7:0]), 'h22);
    idle();
    step();

    // Reset on first cycle of a held read.
    drive(0, 1, 0, 5, 0, 8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("rst mid rd rdy0", int'(M_DataRdy[0]), 0);
    step();
    @(negedge clock);
    check("rd after rst rdy0", int'(M_DataRdy[0]), 1);
    check("rd after rst data0", int'(M_Rdata_ram[7:0]), 'hA5);
    idle();
    step();

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      for (int c = 0; c < 2; c++) begin
        int r, a;
        bit oe, we;
        r  = $urandom_range(0, 99);
        oe = (r < 35) || (r == 99);
        we = (r >= 35 && r < 70) || (r == 99);
        a  = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 127) : $urandom_range(0, 31);
        drive(c, oe, we, a, $urandom_range(0, 255), $urandom_range(0, 15));
      end
      init_we = ($urandom_range(0, 9) == 0);
      init_addr = 5'($urandom_range(0, 31));
      init_data = 8'($urandom);
      step();
    end
    reset = 1'b0;
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
